// File: rtl/arch_map_table_pkg.sv
// Shared types for the architectural (retirement) map table.
// Default sizes come from `ARCH_REG_SZ and `N when the build does not set them.
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 31
`endif
`ifndef N
`define N 2
`endif

package arch_map_table_pkg;

    localparam int unsigned ARCH_REGS    = `ARCH_REG_SZ;
    localparam int unsigned N_LANES      = `N;
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned PHYS_IDX_W   = 6;

    typedef logic [REG_IDX_W-1:0]  REG_IDX;
    typedef logic [PHYS_IDX_W-1:0] PHYS_REG_IDX;

    typedef struct packed {
        PHYS_REG_IDX reg_idx;
        logic        ready;
        logic        valid;
    } MAP_TABLE_PACKET;

    typedef enum logic [1:0] {
        IDLE,
        RESTORE,
        SETTLE
    } AMT_STATE;

    function automatic MAP_TABLE_PACKET mk_entry(input PHYS_REG_IDX p);
        MAP_TABLE_PACKET e;
        e.reg_idx = p;
        e.ready   = 1'b1;
        e.valid   = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/amt_commit_lanes.sv
// Combinational in-order commit of N retire lanes onto a copy of the map table.
module amt_commit_lanes
    import arch_map_table_pkg::*;
#(
    parameter int unsigned DEPTH = ARCH_REGS,
    parameter int unsigned N     = N_LANES
) (
    input  MAP_TABLE_PACKET [DEPTH:0] i_table,
    input  logic            [N-1:0]   i_valid,
    input  REG_IDX          [N-1:0]   i_arch,
    input  PHYS_REG_IDX     [N-1:0]   i_phys,
    output MAP_TABLE_PACKET [DEPTH:0] o_table,
    output logic            [N-1:0]   o_freed_valid,
    output PHYS_REG_IDX     [N-1:0]   o_freed_phys
);

    MAP_TABLE_PACKET [DEPTH:0] w_work;

    // Later lanes see earlier lanes' writes, so a repeated arch reg frees the
    // phys reg the older lane just installed.
    always_comb begin
        w_work        = i_table;
        o_freed_valid = '0;
        o_freed_phys  = '0;
        for (int unsigned l = 0; l < N; l++) begin
            if (i_valid[l]) begin
                for (int unsigned j = 1; j <= DEPTH; j++) begin
                    if (i_arch[l] == REG_IDX'(j)) begin
                        o_freed_valid[l] = 1'b1;
                        o_freed_phys[l]  = w_work[j].reg_idx;
                        w_work[j]        = mk_entry(i_phys[l]);
                    end
                end
            end
        end
        o_table = w_work;
    end

endmodule

// File: rtl/arch_map_table.sv
// Retirement-side rename map: commits retire lanes, frees displaced phys regs,
// and pushes a committed snapshot on rollback. Optional: AMT_RETIRE_COUNT_EN.
module arch_map_table
    import arch_map_table_pkg::*;
#(
    parameter int unsigned DEPTH = ARCH_REGS,
    parameter int unsigned N     = N_LANES
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic            [N-1:0]   retire_valid,
    input  REG_IDX          [N-1:0]   retire_arch_idx,
    input  PHYS_REG_IDX     [N-1:0]   retire_phys_idx,
    input  logic                      rollback,
    output logic            [N-1:0]   freed_valid,
    output PHYS_REG_IDX     [N-1:0]   freed_phys_idx,
    output logic                      restore_en,
    output MAP_TABLE_PACKET [DEPTH:0] restore_mt,
    output logic                      busy
`ifdef AMT_RETIRE_COUNT_EN
    ,
    output logic            [63:0]    retire_count
`endif
);

    AMT_STATE                  r_state;
    MAP_TABLE_PACKET [DEPTH:0] r_entries;

    MAP_TABLE_PACKET [DEPTH:0] w_next;
    MAP_TABLE_PACKET [DEPTH:0] w_snapshot;
    logic            [N-1:0]   w_freed_valid;
    PHYS_REG_IDX     [N-1:0]   w_freed_phys;

    amt_commit_lanes #(
        .DEPTH (DEPTH),
        .N     (N)
    ) u_commit (
        .i_table       (r_entries),
        .i_valid       (retire_valid),
        .i_arch        (retire_arch_idx),
        .i_phys        (retire_phys_idx),
        .o_table       (w_next),
        .o_freed_valid (w_freed_valid),
        .o_freed_phys  (w_freed_phys)
    );

    always_comb begin
        w_snapshot = w_next;
        for (int unsigned i = 0; i <= DEPTH; i++) begin
            w_snapshot[i].ready = 1'b1;
        end
        w_snapshot[0] = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            for (int unsigned i = 0; i <= DEPTH; i++) begin
                if (i == 0) begin
                    r_entries[i] <= '0;
                end else begin
                    r_entries[i] <= mk_entry(PHYS_REG_IDX'(i));
                end
            end
            freed_valid    <= '0;
            freed_phys_idx <= '0;
            restore_en     <= 1'b0;
            restore_mt     <= '0;
            busy           <= 1'b0;
`ifdef AMT_RETIRE_COUNT_EN
            retire_count   <= '0;
`endif
        end else begin
            freed_valid    <= '0;
            freed_phys_idx <= '0;
            restore_en     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_entries      <= w_next;
                    freed_valid    <= w_freed_valid;
                    freed_phys_idx <= w_freed_phys;
`ifdef AMT_RETIRE_COUNT_EN
                    retire_count   <= retire_count + 64'($countones(retire_valid));
`endif
                    // Snapshot includes this cycle's commits.
                    if (rollback) begin
                        r_state    <= RESTORE;
                        restore_en <= 1'b1;
                        restore_mt <= w_snapshot;
                        busy       <= 1'b1;
                    end
                end
                RESTORE: begin
                    r_state <= SETTLE;
                    busy    <= 1'b1;
                end
                SETTLE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arch_map_table.sv
// Self-checking bench for arch_map_table against an array-based rename model.
module tb_arch_map_table;
    import arch_map_table_pkg::*;

    localparam int unsigned D  = ARCH_REGS;
    localparam int unsigned NL = N_LANES;

    typedef MAP_TABLE_PACKET [D:0] tbl_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic        [NL-1:0]    retire_valid;
    REG_IDX      [NL-1:0]    retire_arch_idx;
    PHYS_REG_IDX [NL-1:0]    retire_phys_idx;
    logic                    rollback;
    logic        [NL-1:0]    freed_valid;
    PHYS_REG_IDX [NL-1:0]    freed_phys_idx;
    logic                    restore_en;
    tbl_t                    restore_mt;
    logic                    busy;
`ifdef AMT_RETIRE_COUNT_EN
    logic        [63:0]      retire_count;
    logic        [63:0]      exp_count;
`endif

    int          errors;
    int          checks;
    int          ref_map [D+1];
    int          phase;
    logic        [NL-1:0]    exp_fv;
    PHYS_REG_IDX [NL-1:0]    exp_fp;
    logic                    exp_ren;
    logic                    exp_busy;
    tbl_t                    exp_mt;

    arch_map_table #(.DEPTH(D), .N(NL)) dut (
        .clock           (clock),
        .reset           (reset),
        .retire_valid    (retire_valid),
        .retire_arch_idx (retire_arch_idx),
        .retire_phys_idx (retire_phys_idx),
        .rollback        (rollback),
        .freed_valid     (freed_valid),
        .freed_phys_idx  (freed_phys_idx),
        .restore_en      (restore_en),
        .restore_mt      (restore_mt),
        .busy            (busy)
`ifdef AMT_RETIRE_COUNT_EN
        ,
        .retire_count    (retire_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic tbl_t model_tbl();
        tbl_t t;
        t = '0;
        for (int i = 1; i <= int'(D); i++) begin
            t[i].reg_idx = PHYS_REG_IDX'(ref_map[i]);
            t[i].ready   = 1'b1;
            t[i].valid   = 1'b1;
        end
        return t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= int'(D); i++) ref_map[i] = i;
        phase    = 0;
        exp_fv   = '0;
        exp_fp   = '0;
        exp_ren  = 1'b0;
        exp_busy = 1'b0;
        exp_mt   = '0;
`ifdef AMT_RETIRE_COUNT_EN
        exp_count = '0;
`endif
    endtask

    // Expected outputs after the next rising edge, from the current inputs.
    task automatic model_edge();
        exp_fv  = '0;
        exp_fp  = '0;
        exp_ren = 1'b0;
        if (phase == 0) begin
            for (int l = 0; l < int'(NL); l++) begin
                if (retire_valid[l]) begin
`ifdef AMT_RETIRE_COUNT_EN
                    exp_count = exp_count + 64'd1;
`endif
                    if (retire_arch_idx[l] != 0) begin
                        exp_fv[l] = 1'b1;
                        exp_fp[l] = PHYS_REG_IDX'(ref_map[int'(retire_arch_idx[l])]);
                        ref_map[int'(retire_arch_idx[l])] = int'(retire_phys_idx[l]);
                    end
                end
            end
            if (rollback) begin
                exp_ren  = 1'b1;
                exp_busy = 1'b1;
                exp_mt   = model_tbl();
                phase    = 1;
            end else begin
                exp_busy = 1'b0;
            end
        end else if (phase == 1) begin
            exp_busy = 1'b1;
            phase    = 2;
        end else begin
            exp_busy = 1'b0;
            phase    = 0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        retire_valid    = '0;
        retire_arch_idx = '0;
        retire_phys_idx = '0;
        rollback        = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (dut.r_entries[5].reg_idx !== PHYS_REG_IDX'(5)) begin errors++; $display("FAIL reset_entry5: got %0d expected 5", dut.r_entries[5].reg_idx); end
        checks++; if (dut.r_entries[5].ready !== 1'b1) begin errors++; $display("FAIL reset_ready5: got %b expected 1", dut.r_entries[5].ready); end
        checks++; if (freed_valid !== '0) begin errors++; $display("FAIL reset_freed: got %b expected 0", freed_valid); end
        checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL reset_restore_en: got %b expected 0", restore_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (restore_mt !== '0) begin errors++; $display("FAIL reset_restore_mt: got %h expected 0", restore_mt); end
        reset = 1'b1;
        tick();
        checks++; if (freed_valid !== '0) begin errors++; $display("FAIL post_reset_freed: got %b expected 0", freed_valid); end
    endtask

    task automatic test_single_retire();
        retire_valid       = '0;
        retire_valid[0]    = 1'b1;
        retire_arch_idx[0] = REG_IDX'(5);
        retire_phys_idx[0] = PHYS_REG_IDX'(40);
        tick();
        idle_inputs();
        checks++; if (freed_valid[0] !== 1'b1) begin errors++; $display("FAIL single_fv: got %b expected 1", freed_valid[0]); end
        checks++; if (freed_phys_idx[0] !== PHYS_REG_IDX'(5)) begin errors++; $display("FAIL single_fp: got %0d expected 5", freed_phys_idx[0]); end
        checks++; if (dut.r_entries[5].reg_idx !== PHYS_REG_IDX'(40)) begin errors++; $display("FAIL single_entry: got %0d expected 40", dut.r_entries[5].reg_idx); end
        tick();
        checks++; if (freed_valid !== '0) begin errors++; $display("FAIL single_idle_fv: got %b expected 0", freed_valid); end
    endtask

    task automatic test_same_reg();
        retire_valid       = '0;
        retire_valid[0]    = 1'b1;
        retire_valid[1]    = 1'b1;
        retire_arch_idx[0] = REG_IDX'(3);
        retire_phys_idx[0] = PHYS_REG_IDX'(40);
        retire_arch_idx[1] = REG_IDX'(3);
        retire_phys_idx[1] = PHYS_REG_IDX'(41);
        tick();
        idle_inputs();
        checks++; if (freed_valid[1:0] !== 2'b11) begin errors++; $display("FAIL same_fv: got %b expected 11", freed_valid[1:0]); end
        checks++; if (freed_phys_idx[0] !== PHYS_REG_IDX'(3)) begin errors++; $display("FAIL same_fp0: got %0d expected 3", freed_phys_idx[0]); end
        checks++; if (freed_phys_idx[1] !== PHYS_REG_IDX'(40)) begin errors++; $display("FAIL same_fp1: got %0d expected 40", freed_phys_idx[1]); end
        checks++; if (dut.r_entries[3].reg_idx !== PHYS_REG_IDX'(41)) begin errors++; $display("FAIL same_entry: got %0d expected 41", dut.r_entries[3].reg_idx); end
    endtask

    task automatic test_zero_arch();
`ifdef AMT_RETIRE_COUNT_EN
        logic [63:0] before;
        before = retire_count;
`endif
        retire_valid       = '0;
        retire_valid[0]    = 1'b1;
        retire_arch_idx[0] = '0;
        retire_phys_idx[0] = PHYS_REG_IDX'(9);
        tick();
        idle_inputs();
        checks++; if (freed_valid !== '0) begin errors++; $display("FAIL zero_fv: got %b expected 0", freed_valid); end
        checks++; if (dut.r_entries !== model_tbl()) begin errors++; $display("FAIL zero_table: got %h expected %h", dut.r_entries, model_tbl()); end
`ifdef AMT_RETIRE_COUNT_EN
        checks++; if (retire_count !== before + 64'd1) begin errors++; $display("FAIL zero_count: got %0d expected %0d", retire_count, before + 64'd1); end
`endif
    endtask

    task automatic test_rollback();
        MAP_TABLE_PACKET want7;
        want7 = mk_entry(PHYS_REG_IDX'(50));
        retire_valid       = '0;
        retire_valid[0]    = 1'b1;
        retire_arch_idx[0] = REG_IDX'(7);
        retire_phys_idx[0] = PHYS_REG_IDX'(50);
        rollback           = 1'b1;
        tick();
        checks++; if (restore_en !== 1'b1) begin errors++; $display("FAIL rb_restore_en: got %b expected 1", restore_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b expected 1", busy); end
        checks++; if (restore_mt[7] !== want7) begin errors++; $display("FAIL rb_mt7: got %h expected %h", restore_mt[7], want7); end
        checks++; if (restore_mt !== exp_mt) begin errors++; $display("FAIL rb_mt: got %h expected %h", restore_mt, exp_mt); end
        checks++; if (freed_phys_idx[0] !== PHYS_REG_IDX'(7)) begin errors++; $display("FAIL rb_fp: got %0d expected 7", freed_phys_idx[0]); end
        // Retire and rollback attempts during recovery must be dropped.
        retire_valid       = '0;
        retire_valid[0]    = 1'b1;
        retire_arch_idx[0] = REG_IDX'(9);
        retire_phys_idx[0] = PHYS_REG_IDX'(33);
        rollback           = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL settle_busy: got %b expected 1", busy); end
        checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL settle_restore_en: got %b expected 0", restore_en); end
        checks++; if (freed_valid !== '0) begin errors++; $display("FAIL settle_fv: got %b expected 0", freed_valid); end
        tick();
        idle_inputs();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        checks++; if (freed_valid !== '0) begin errors++; $display("FAIL idle_fv: got %b expected 0", freed_valid); end
        checks++; if (dut.r_entries[9].reg_idx !== PHYS_REG_IDX'(9)) begin errors++; $display("FAIL settle_entry9: got %0d expected 9", dut.r_entries[9].reg_idx); end
        checks++; if (restore_mt !== exp_mt) begin errors++; $display("FAIL rb_mt_hold: got %h expected %h", restore_mt, exp_mt); end
    endtask

    task automatic test_reset_mid_restore();
        retire_valid       = '0;
        retire_valid[0]    = 1'b1;
        retire_arch_idx[0] = REG_IDX'(2);
        retire_phys_idx[0] = PHYS_REG_IDX'(60);
        rollback           = 1'b1;
        tick();
        idle_inputs();
        checks++; if (restore_en !== 1'b1) begin errors++; $display("FAIL mid_pre_restore_en: got %b expected 1", restore_en); end
        #1 reset = 1'b0;
        #1;
        model_reset();
        checks++; if (restore_en !== 1'b0) begin errors++; $display("FAIL mid_restore_en: got %b expected 0", restore_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (dut.r_entries !== model_tbl()) begin errors++; $display("FAIL mid_table: got %h expected %h", dut.r_entries, model_tbl()); end
        @(posedge clock);
        #1 reset = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || restore_en !== 1'b0) begin errors++; $display("FAIL mid_after: got busy=%b en=%b expected 0 0", busy, restore_en); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int l = 0; l < int'(NL); l++) begin
                retire_valid[l]    = 1'($urandom_range(0, 1));
                retire_arch_idx[l] = REG_IDX'($urandom_range(0, D));
                retire_phys_idx[l] = PHYS_REG_IDX'($urandom);
            end
            rollback = ($urandom_range(0, 9) == 0);
            tick();
            checks++; if (freed_valid !== exp_fv) begin errors++; $display("FAIL rnd_fv[%0d]: got %b expected %b", n, freed_valid, exp_fv); end
            checks++; if (freed_phys_idx !== exp_fp) begin errors++; $display("FAIL rnd_fp[%0d]: got %h expected %h", n, freed_phys_idx, exp_fp); end
            checks++; if (restore_en !== exp_ren) begin errors++; $display("FAIL rnd_en[%0d]: got %b expected %b", n, restore_en, exp_ren); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", n, busy, exp_busy); end
            checks++; if (restore_mt !== exp_mt) begin errors++; $display("FAIL rnd_mt[%0d]: got %h expected %h", n, restore_mt, exp_mt); end
            checks++; if (dut.r_entries !== model_tbl()) begin errors++; $display("FAIL rnd_table[%0d]: got %h expected %h", n, dut.r_entries, model_tbl()); end
`ifdef AMT_RETIRE_COUNT_EN
            checks++; if (retire_count !== exp_count) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, retire_count, exp_count); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_retire();
        test_same_reg();
        test_zero_arch();
        test_rollback();
        test_reset_mid_restore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
